// File: rtl/pg_alu_domain.sv
// rtl/pg_alu_domain.sv - power-gated ALU domain with sequencing FSM, isolation clamp and result retention
module pg_alu_domain #(
   parameter int               WIDTH      = 16,
   parameter logic [WIDTH-1:0] CLAMP_VAL  = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int               PWR_UP_CYC = 4,
   parameter int               PWR_DN_CYC = 2,
   parameter int               MUL_CYC    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   input  logic             start,
   input  logic             wake_req,
   input  logic             sleep_req,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             busy,
   output logic             iso_active,
   output logic             pwr_en,
   output logic [1:0]       pd_state,
   output logic             err_dropped
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int PMAX = (PWR_UP_CYC > PWR_DN_CYC) ? PWR_UP_CYC : PWR_DN_CYC;
   localparam int PCW  = $clog2(PMAX + 1);
   localparam int MCW  = $clog2(MUL_CYC + 1);

   // Counters run from LOAD down to 0, so a phase lasts LOAD+1 cycles.
   localparam logic [PCW-1:0] UP_LOAD  = PCW'(PWR_UP_CYC - 1);
   localparam logic [PCW-1:0] DN_LOAD  = PCW'(PWR_DN_CYC - 1);
   localparam logic [MCW-1:0] MUL_LOAD = MCW'(MUL_CYC - 2);
   localparam logic [3:0]     OP_MUL   = 4'd7;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_WAKING   = 2'd1,
      ST_ON       = 2'd2,
      ST_SLEEPING = 2'd3
   } pd_state_e;

   pd_state_e        state_q, state_d;
   logic [PCW-1:0]   pcnt_q, pcnt_d;
   logic             pwr_en_q, pwr_en_d;
   logic             iso_q, iso_d;
   logic             sleep_pend_q, sleep_pend_d;
   logic             busy_q, busy_d;
   logic [MCW-1:0]   mcnt_q, mcnt_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic [WIDTH-1:0] ret_q, ret_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] mul_res;
   logic             accept;

   // Single-cycle ALU result; opcode 7 is handled by the multi-cycle multiplier.
   always_comb begin
      alu_res = '0;
      case (opcode)
         4'd0:    alu_res = a + b;
         4'd1:    alu_res = a - b;
         4'd2:    alu_res = a & b;
         4'd3:    alu_res = a | b;
         4'd4:    alu_res = a ^ b;
         4'd5:    alu_res = a << b[SHW-1:0];
         4'd6:    alu_res = a >> b[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   assign mul_res = mul_a_q * mul_b_q;

   // A start is only taken while powered, idle and with no sleep in the pipe.
   assign accept = (state_q == ST_ON) && !busy_q && !sleep_req && !sleep_pend_q;

   // Next-state logic for the power sequencer, operation issue and retention.
   always_comb begin
      state_d      = state_q;
      pcnt_d       = pcnt_q;
      pwr_en_d     = pwr_en_q;
      iso_d        = iso_q;
      sleep_pend_d = sleep_pend_q;
      busy_d       = busy_q;
      mcnt_d       = mcnt_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      ret_d        = ret_q;
      valid_d      = 1'b0;
      err_d        = 1'b0;

      if (start) begin
         if (accept) begin
            if (opcode == OP_MUL) begin
               busy_d  = 1'b1;
               mcnt_d  = MUL_LOAD;
               mul_a_d = a;
               mul_b_d = b;
            end else begin
               ret_d   = alu_res;
               valid_d = 1'b1;
            end
         end else begin
            err_d = 1'b1;
         end
      end

      // Multiply completes on its last busy cycle so busy drops with the valid pulse.
      if (busy_q) begin
         if (mcnt_q == '0) begin
            busy_d  = 1'b0;
            ret_d   = mul_res;
            valid_d = 1'b1;
         end else begin
            mcnt_d = mcnt_q - 1'b1;
         end
      end

      case (state_q)
         ST_OFF: begin
            if (wake_req && !sleep_req) begin
               state_d  = ST_WAKING;
               pcnt_d   = UP_LOAD;
               pwr_en_d = 1'b1;
               iso_d    = 1'b1;
            end
         end
         ST_WAKING: begin
            if (pcnt_q == '0) begin
               state_d = ST_ON;
               iso_d   = 1'b0;
            end else begin
               pcnt_d = pcnt_q - 1'b1;
            end
         end
         ST_ON: begin
            if ((sleep_req || sleep_pend_q) && !busy_q) begin
               state_d      = ST_SLEEPING;
               iso_d        = 1'b1;
               pcnt_d       = DN_LOAD;
               sleep_pend_d = 1'b0;
            end else if (sleep_req) begin
               sleep_pend_d = 1'b1;
            end
         end
         ST_SLEEPING: begin
            if (pcnt_q == '0) begin
               state_d  = ST_OFF;
               pwr_en_d = 1'b0;
            end else begin
               pcnt_d = pcnt_q - 1'b1;
            end
         end
      endcase
   end

   // State and output registers; reset discards any in-flight multiply.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_OFF;
         pcnt_q       <= '0;
         pwr_en_q     <= 1'b0;
         iso_q        <= 1'b1;
         sleep_pend_q <= 1'b0;
         busy_q       <= 1'b0;
         mcnt_q       <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         ret_q        <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pcnt_q       <= pcnt_d;
         pwr_en_q     <= pwr_en_d;
         iso_q        <= iso_d;
         sleep_pend_q <= sleep_pend_d;
         busy_q       <= busy_d;
         mcnt_q       <= mcnt_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         ret_q        <= ret_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
      end
   end

   assign result       = iso_q ? CLAMP_VAL : ret_q;
   assign result_valid = valid_q;
   assign busy         = busy_q;
   assign iso_active   = iso_q;
   assign pwr_en       = pwr_en_q;
   assign pd_state     = state_q;
   assign err_dropped  = err_q;

endmodule

// File: tb/tb_pg_alu_domain.sv
// tb/tb_pg_alu_domain.sv - randomized self-checking bench for pg_alu_domain against a timestamp model
module tb_pg_alu_domain;

   localparam int W    = 16;
   localparam int UP   = 4;
   localparam int DN   = 2;
   localparam int MUL  = 4;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [3:0]    opcode;
   logic          start;
   logic          wake_req;
   logic          sleep_req;
   logic [W-1:0]  result;
   logic          result_valid;
   logic          busy;
   logic          iso_active;
   logic          pwr_en;
   logic [1:0]    pd_state;
   logic          err_dropped;

   int n_cmp = 0;
   int n_bad = 0;

   // model: mode uses the external pd_state numbering, phases end at absolute cycle stamps
   int           cyc = 0;
   bit           model_ok = 0;
   int           m_mode;
   int           t_on, t_off;
   bit           m_pend;
   bit           m_live;
   int           m_done;
   logic [W-1:0] m_mval;
   logic [W-1:0] m_ret;
   bit           m_valid;
   bit           m_err;

   pg_alu_domain #(
      .WIDTH      (W),
      .CLAMP_VAL  (16'h0001),
      .PWR_UP_CYC (UP),
      .PWR_DN_CYC (DN),
      .MUL_CYC    (MUL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a            (a),
      .b            (b),
      .opcode       (opcode),
      .start        (start),
      .wake_req     (wake_req),
      .sleep_req    (sleep_req),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .iso_active   (iso_active),
      .pwr_en       (pwr_en),
      .pd_state     (pd_state),
      .err_dropped  (err_dropped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned ux, uy, r;
      ux = x;
      uy = y;
      case (op)
         4'd0:    r = (ux + uy) % 65536;
         4'd1:    r = (ux + 65536 - uy) % 65536;
         4'd2:    r = ux & uy;
         4'd3:    r = ux | uy;
         4'd4:    r = ux ^ uy;
         4'd5:    r = (ux * (32'd1 << (uy % W))) % 65536;
         4'd6:    r = ux / (32'd1 << (uy % W));
         4'd7:    r = (ux * uy) % 65536;
         default: r = 0;
      endcase
      return W'(r);
   endfunction

   task automatic check_outputs();
      bit iso;
      if (!model_ok) return;
      iso = (m_mode != 2);
      check_eq("result",       result,       iso ? 32'h1 : 32'(m_ret));
      check_eq("result_valid", result_valid, m_valid);
      check_eq("busy",         busy,         m_live);
      check_eq("iso_active",   iso_active,   iso);
      check_eq("pwr_en",       pwr_en,       m_mode != 0);
      check_eq("pd_state",     pd_state,     m_mode);
      check_eq("err_dropped",  err_dropped,  m_err);
   endtask

   // advance the model across the coming rising edge using the inputs now applied
   task automatic model_step();
      int           nm;
      bit           n_pend, n_live, n_valid, n_err, acc;
      logic [W-1:0] n_ret;
      if (!rst_n) begin
         m_mode = 0; m_pend = 0; m_live = 0; m_ret = '0;
         m_valid = 0; m_err = 0; model_ok = 1;
         cyc++;
         return;
      end
      nm = m_mode; n_pend = m_pend; n_live = m_live; n_ret = m_ret;
      n_valid = 0; n_err = 0;
      acc = start && (m_mode == 2) && !m_live && !sleep_req && !m_pend;
      if (start && !acc) n_err = 1;
      if (m_live && (cyc + 1 == m_done)) begin
         n_ret = m_mval; n_valid = 1; n_live = 0;
      end
      if (acc) begin
         if (opcode == 4'd7) begin
            n_live = 1;
            m_done = cyc + MUL;
            m_mval = ref_alu(4'd7, a, b);
         end else begin
            n_ret = ref_alu(opcode, a, b);
            n_valid = 1;
         end
      end
      case (m_mode)
         0: if (wake_req && !sleep_req) begin nm = 1; t_on = cyc + 1 + UP; end
         1: if (cyc + 1 == t_on) nm = 2;
         2: begin
            if (m_live) begin
               if (sleep_req) n_pend = 1;
            end else if (sleep_req || m_pend) begin
               nm = 3; t_off = cyc + 1 + DN; n_pend = 0;
            end
         end
         default: if (cyc + 1 == t_off) nm = 0;
      endcase
      m_mode = nm; m_pend = n_pend; m_live = n_live; m_ret = n_ret;
      m_valid = n_valid; m_err = n_err;
      cyc++;
   endtask

   task automatic tick(input logic r, input logic w, input logic s, input logic st,
                       input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
      check_outputs();
      rst_n = r; wake_req = w; sleep_req = s; start = st;
      opcode = op; a = aa; b = bb;
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 4'd0, '0, '0);
   endtask

   initial begin
      rst_n = 1'b0; a = '0; b = '0; opcode = '0;
      start = 1'b0; wake_req = 1'b0; sleep_req = 1'b0;
      @(negedge clk);

      // reset and wake sequencing
      tick(0, 0, 0, 0, 4'd0, '0, '0);
      check_eq("rst_result", result, 32'h1);
      check_eq("rst_iso", iso_active, 1);
      tick(1, 1, 0, 0, 4'd0, '0, '0);
      check_eq("wake_pd1", pd_state, 1);
      check_eq("wake_pwr1", pwr_en, 1);
      idle(3);
      check_eq("wake_still_iso", iso_active, 1);
      idle(1);
      check_eq("on_pd2", pd_state, 2);
      check_eq("on_result0", result, 32'h0);

      // single-cycle ops
      tick(1, 0, 0, 1, 4'd0, 16'hFFFF, 16'h0002);
      check_eq("add_wrap", result, 32'h0001);
      check_eq("add_valid", result_valid, 1);
      tick(1, 0, 0, 1, 4'd5, 16'h0001, 16'h0013);
      check_eq("shl_mod", result, 32'h0008);
      idle(1);

      // multiply with a dropped start while busy
      tick(1, 0, 0, 1, 4'd7, 16'h0100, 16'h0101);
      check_eq("mul_busy", busy, 1);
      tick(1, 0, 0, 1, 4'd0, 16'h1234, 16'h1111);
      check_eq("drop_err", err_dropped, 1);
      idle(2);
      check_eq("mul_result", result, 32'h0100);
      check_eq("mul_busy_fall", busy, 0);

      // sleep requested mid-multiply
      tick(1, 0, 0, 1, 4'd7, 16'h0100, 16'h0101);
      tick(1, 0, 1, 0, 4'd0, '0, '0);
      idle(2);
      check_eq("sleep_mul_valid", result_valid, 1);
      idle(1);
      check_eq("sleep_pd3", pd_state, 3);
      check_eq("sleep_clamp", result, 32'h1);
      idle(2);
      check_eq("off_pwr0", pwr_en, 0);

      // start in OFF, then wake and retention
      tick(1, 0, 0, 1, 4'd0, 16'h0001, 16'h0001);
      check_eq("off_drop", err_dropped, 1);
      tick(1, 1, 0, 0, 4'd0, '0, '0);
      idle(4);
      check_eq("retained", result, 32'h0100);

      // reset mid-wake, wake+sleep collision, reset mid-multiply
      tick(1, 1, 1, 0, 4'd0, '0, '0);
      idle(3);
      tick(1, 0, 0, 0, 4'd0, '0, '0);
      tick(0, 0, 0, 0, 4'd0, '0, '0);
      tick(1, 1, 0, 0, 4'd0, '0, '0);
      idle(1);
      tick(0, 0, 0, 0, 4'd0, '0, '0);
      check_eq("rst_wake_pd", pd_state, 0);
      tick(1, 1, 1, 0, 4'd0, '0, '0);
      check_eq("collide_off", pd_state, 0);
      tick(1, 1, 0, 0, 4'd0, '0, '0);
      idle(4);
      tick(1, 0, 0, 1, 4'd7, 16'h0003, 16'h0005);
      tick(0, 0, 0, 0, 4'd0, '0, '0);
      check_eq("rst_mul_busy", busy, 0);
      check_eq("rst_mul_result", result, 32'h1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] op;
         op = ($urandom % 4 == 0) ? 4'd7 : 4'($urandom % 16);
         tick(($urandom % 300) != 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
              ($urandom % 2) == 1, op, W'($urandom), W'($urandom));
      end
      check_outputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
